// File: rtl/simple_phase_ctl_if.sv
// Control bundle between the SIMPLE phase sequencer and the datapath.
// master: datapath/bench side (drives exec, ir, szcv; observes strobes).
// slave : the sequencer itself.
// exec is a push-button level with no valid/ready handshake. The strobes are
// plain levels that are valid for the whole cycle of the phase that owns them.
interface simple_phase_ctl_if;
  logic        exec;
  logic [15:0] ir;
  logic [3:0]  szcv;
  logic [4:0]  phase;
  logic        running;
  logic        halted;
  logic        ir_we;
  logic        ab_we;
  logic [3:0]  alu_op;
  logic        alu_a_pc;
  logic        alu_b_imm;
  logic        dr_shift;
  logic        dr_we;
  logic        szcv_we;
  logic        mem_read;
  logic        mem_write;
  logic        mdr_we;
  logic        mdr_ext;
  logic        rf_we;
  logic        wb_mem;
  logic        pc_we;
  logic        pc_src_dr;
  logic        out_we;
  logic [2:0]  state_dbg;

  modport master (
    output exec, ir, szcv,
    input  phase, running, halted, ir_we, ab_we, alu_op, alu_a_pc, alu_b_imm,
           dr_shift, dr_we, szcv_we, mem_read, mem_write, mdr_we, mdr_ext,
           rf_we, wb_mem, pc_we, pc_src_dr, out_we, state_dbg
  );

  modport slave (
    input  exec, ir, szcv,
    output phase, running, halted, ir_we, ab_we, alu_op, alu_a_pc, alu_b_imm,
           dr_shift, dr_we, szcv_we, mem_read, mem_write, mdr_we, mdr_ext,
           rf_we, wb_mem, pc_we, pc_src_dr, out_we, state_dbg
  );
endinterface

// File: rtl/simple_phase_ctl.sv
// Run/stop sequencer and instruction decoder for the SIMPLE multi-cycle core.
// Phases P1..P5 (fetch, reg read, ALU/shift, memory, writeback), plus STOP and
// HALT. Strobes are decoded combinationally from the registered state and ir.
// Optional feature macro: SIMPLE_SINGLE_STEP_EN adds a 'step' input that runs
// exactly one instruction from STOP.
module simple_phase_ctl #(
  parameter int EXEC_SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SIMPLE_SINGLE_STEP_EN
  input  logic step,
`endif
  simple_phase_ctl_if.slave bus
);

  typedef enum logic [2:0] {
    S_STOP = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_P4   = 3'd4,
    S_P5   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t state, state_nx;
  logic   stop_req, stop_req_nx;

  logic [EXEC_SYNC-1:0] exec_sync;
  logic                 exec_prev;
  logic                 exec_p;
  logic                 step_p;

  // Synchronise the asynchronous exec button and keep the previous level for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_sync <= '0;
      exec_prev <= 1'b0;
    end else begin
      exec_sync <= {exec_sync[EXEC_SYNC-2:0], bus.exec};
      exec_prev <= exec_sync[EXEC_SYNC-1];
    end
  end

  assign exec_p = exec_sync[EXEC_SYNC-1] & ~exec_prev;

`ifdef SIMPLE_SINGLE_STEP_EN
  logic [EXEC_SYNC-1:0] step_sync;
  logic                 step_prev;

  // Synchronise the step button the same way as exec
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_sync <= '0;
      step_prev <= 1'b0;
    end else begin
      step_sync <= {step_sync[EXEC_SYNC-2:0], step};
      step_prev <= step_sync[EXEC_SYNC-1];
    end
  end

  assign step_p = step_sync[EXEC_SYNC-1] & ~step_prev;
`else
  assign step_p = 1'b0;
`endif

  // Instruction class decode from ir
  logic [3:0] op3;
  logic       cls_ld, cls_st, cls_br, cls_arith;
  logic       op_alu, op_cmp, op_shift, op_in, op_out, op_hlt;
  logic       op_li, op_b, op_bcc, op_branch, arith_def;
  logic       flag_s, flag_z, flag_v, br_taken;
  logic       unused_bits;

  assign op3       = bus.ir[7:4];
  assign cls_ld    = (bus.ir[15:14] == 2'b00);
  assign cls_st    = (bus.ir[15:14] == 2'b01);
  assign cls_br    = (bus.ir[15:14] == 2'b10);
  assign cls_arith = (bus.ir[15:14] == 2'b11);

  assign op_alu    = cls_arith && (op3 <= 4'd6);
  assign op_cmp    = cls_arith && (op3 == 4'd5);
  assign op_shift  = cls_arith && (op3[3:2] == 2'b10);
  assign op_in     = cls_arith && (op3 == 4'hC);
  assign op_out    = cls_arith && (op3 == 4'hD);
  assign op_hlt    = cls_arith && (op3 == 4'hF);
  assign arith_def = op_alu | op_shift | op_in | op_out | op_hlt;

  assign op_li     = cls_br && (bus.ir[13:11] == 3'b000);
  assign op_b      = cls_br && (bus.ir[13:11] == 3'b100);
  // Only cc 000..011 are defined; the rest decode as NOP.
  assign op_bcc    = cls_br && (bus.ir[13:11] == 3'b111) && !bus.ir[10];
  assign op_branch = op_b | op_bcc;

  assign flag_s = bus.szcv[3];
  assign flag_z = bus.szcv[2];
  assign flag_v = bus.szcv[0];

  // Branch condition from live flags (sampled in P5 where pc_src_dr is used)
  always_comb begin
    br_taken = 1'b0;
    if (op_b) begin
      br_taken = 1'b1;
    end else if (op_bcc) begin
      case (bus.ir[9:8])
        2'b00:   br_taken = flag_z;
        2'b01:   br_taken = flag_s ^ flag_v;
        2'b10:   br_taken = flag_z | (flag_s ^ flag_v);
        default: br_taken = ~flag_z;
      endcase
    end
  end

  assign unused_bits = ^{bus.ir[3:0], bus.szcv[1]};

  // State register; reset forces STOP and drops any pending stop request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_STOP;
      stop_req <= 1'b0;
    end else begin
      state    <= state_nx;
      stop_req <= stop_req_nx;
    end
  end

  // Next-state logic: phase stepping, stop requests, halt
  always_comb begin
    state_nx    = state;
    stop_req_nx = stop_req;
    case (state)
      S_STOP: begin
        if (exec_p) begin
          state_nx    = S_P1;
          stop_req_nx = 1'b0;
        end else if (step_p) begin
          // Single step is a free run that already has its stop requested.
          state_nx    = S_P1;
          stop_req_nx = 1'b1;
        end
      end
      S_P1, S_P2, S_P3, S_P4: begin
        state_nx = state_t'(state + 3'd1);
        if (exec_p) stop_req_nx = 1'b1;
      end
      S_P5: begin
        // A press landing in P5 still stops at this boundary.
        stop_req_nx = 1'b0;
        if (op_hlt) begin
          state_nx = S_HALT;
        end else if (stop_req || exec_p) begin
          state_nx = S_STOP;
        end else begin
          state_nx = S_P1;
        end
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
      default: begin
        state_nx    = S_STOP;
        stop_req_nx = 1'b0;
      end
    endcase
  end

  // Per-phase strobes and selects; everything idles low outside P1..P5
  always_comb begin
    bus.phase     = 5'b00000;
    bus.running   = 1'b0;
    bus.halted    = (state == S_HALT);
    bus.ir_we     = 1'b0;
    bus.ab_we     = 1'b0;
    bus.alu_op    = 4'h0;
    bus.alu_a_pc  = 1'b0;
    bus.alu_b_imm = 1'b0;
    bus.dr_shift  = 1'b0;
    bus.dr_we     = 1'b0;
    bus.szcv_we   = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mdr_we    = 1'b0;
    bus.mdr_ext   = 1'b0;
    bus.rf_we     = 1'b0;
    bus.wb_mem    = 1'b0;
    bus.pc_we     = 1'b0;
    bus.pc_src_dr = 1'b0;
    bus.out_we    = 1'b0;
    bus.state_dbg = state;
    case (state)
      S_P1: begin
        bus.phase   = 5'b00001;
        bus.running = 1'b1;
        bus.ir_we   = 1'b1;
      end
      S_P2: begin
        bus.phase   = 5'b00010;
        bus.running = 1'b1;
        bus.ab_we   = 1'b1;
      end
      S_P3: begin
        bus.phase     = 5'b00100;
        bus.running   = 1'b1;
        bus.dr_we     = 1'b1;
        bus.alu_op    = arith_def ? op3 : 4'h0;
        bus.alu_a_pc  = op_branch;
        bus.alu_b_imm = cls_ld | cls_st | op_li | op_branch;
        bus.dr_shift  = op_shift;
        bus.szcv_we   = op_alu | op_shift;
      end
      S_P4: begin
        bus.phase     = 5'b01000;
        bus.running   = 1'b1;
        bus.mem_read  = cls_ld;
        bus.mem_write = cls_st;
        bus.mdr_we    = cls_ld | op_in;
        bus.mdr_ext   = op_in;
      end
      S_P5: begin
        bus.phase     = 5'b10000;
        bus.running   = 1'b1;
        bus.pc_we     = 1'b1;
        bus.pc_src_dr = op_branch & br_taken;
        bus.rf_we     = (op_alu & ~op_cmp) | op_shift | op_in | cls_ld | op_li;
        bus.wb_mem    = cls_ld | op_in;
        bus.out_we    = op_out;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_simple_phase_ctl.sv
// Bench for simple_phase_ctl: directed and random instructions through a
// per-phase expected-vector queue, plus stop, halt, reset and step scenarios.
module tb_simple_phase_ctl;
  localparam int W = 27;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef SIMPLE_SINGLE_STEP_EN
  logic step = 1'b0;
`endif

  simple_phase_ctl_if bus ();

  simple_phase_ctl #(.EXEC_SYNC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SIMPLE_SINGLE_STEP_EN
    .step  (step),
`endif
    .bus   (bus)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  localparam logic [W-1:0] HALT_VEC = 27'(1) << 25;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // {running, halted, phase, ir_we, ab_we, alu_op, alu_a_pc, alu_b_imm, dr_shift, dr_we,
  //  szcv_we, mem_read, mem_write, mdr_we, mdr_ext, rf_we, wb_mem, pc_we, pc_src_dr, out_we}
  function automatic logic [W-1:0] dut_vec();
    return {bus.running, bus.halted, bus.phase, bus.ir_we, bus.ab_we, bus.alu_op,
            bus.alu_a_pc, bus.alu_b_imm, bus.dr_shift, bus.dr_we, bus.szcv_we,
            bus.mem_read, bus.mem_write, bus.mdr_we, bus.mdr_ext, bus.rf_we,
            bus.wb_mem, bus.pc_we, bus.pc_src_dr, bus.out_we};
  endfunction

  // Reference model: expected vector for instruction i, flags f, phase index p (0=P1)
  function automatic logic [W-1:0] model(input logic [15:0] i, input logic [3:0] f, input int p);
    logic ld, st, li, br, taken, alu_wr, cmp, sh, inp, outp, hlt;
    logic [3:0] op, aop;
    logic [13:0] s;
    logic irw, abw;
    logic [4:0] ph;
    ld = 0; st = 0; li = 0; br = 0; taken = 0; alu_wr = 0; cmp = 0;
    sh = 0; inp = 0; outp = 0; hlt = 0;
    aop = 4'h0; s = '0; irw = 0; abw = 0;
    op = i[7:4];
    ph = 5'b00001 << p;
    case (i[15:14])
      2'b00: ld = 1;
      2'b01: st = 1;
      2'b10: begin
        case (i[13:11])
          3'b000: li = 1;
          3'b100: begin br = 1; taken = 1; end
          3'b111: begin
            if (!i[10]) begin
              br = 1;
              case (i[9:8])
                2'b00:   taken = f[2];
                2'b01:   taken = f[3] ^ f[0];
                2'b10:   taken = f[2] | (f[3] ^ f[0]);
                default: taken = ~f[2];
              endcase
            end
          end
          default: ;
        endcase
      end
      default: begin
        case (op)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6: alu_wr = 1;
          4'h5: cmp = 1;
          4'h8, 4'h9, 4'hA, 4'hB: sh = 1;
          4'hC: inp = 1;
          4'hD: outp = 1;
          4'hF: hlt = 1;
          default: ;
        endcase
      end
    endcase
    case (p)
      0: irw = 1;
      1: abw = 1;
      2: begin
        s[10] = 1;
        s[13] = br;
        s[12] = ld | st | li | br;
        s[11] = sh;
        s[9]  = alu_wr | cmp | sh;
        aop   = (alu_wr | cmp | sh | inp | outp | hlt) ? op : 4'h0;
      end
      3: begin
        s[8] = ld;
        s[7] = st;
        s[6] = ld | inp;
        s[5] = inp;
      end
      default: begin
        s[2] = 1;
        s[4] = alu_wr | sh | inp | ld | li;
        s[3] = ld | inp;
        s[1] = br & taken;
        s[0] = outp;
      end
    endcase
    return {1'b1, 1'b0, ph, irw, abw, aop, s};
  endfunction

  // Expect the controller idle (STOP) for n cycles
  task automatic idle_check(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_eq(tag, dut_vec(), '0);
    end
  endtask

  task automatic press_exec();
    bus.exec = 1'b1;
    repeat (2) @(negedge clk);
    bus.exec = 1'b0;
  endtask

  // Bounded wait for the first P1; leaves time at the negedge inside P1
  task automatic wait_running(input string tag);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.running) break;
    end
    check_eq(tag, W'(bus.phase), W'(5'b00001));
  endtask

  // Called at a negedge inside P1: drive ir/flags, queue five phase vectors, compare each
  task automatic run_instr(input string tag, input logic [15:0] i, input logic [3:0] f,
                           input bit press_p2);
    bus.ir = i;
    bus.szcv = f;
    #1;
    for (int p = 0; p < 5; p++) exp_q.push_back(model(i, f, p));
    for (int p = 0; p < 5; p++) begin
      if (p > 0) @(negedge clk);
      check_eq(tag, dut_vec(), exp_q.pop_front());
      if (press_p2 && p == 1) bus.exec = 1'b1;
      if (press_p2 && p == 2) bus.exec = 1'b0;
    end
  endtask

  logic [15:0] d_ir [20] = '{16'hC100, 16'hC110, 16'hC150, 16'hC160, 16'hC180,
                             16'hC1B0, 16'hC1C0, 16'hC1D0, 16'hC170, 16'h0000,
                             16'h4000, 16'h8005, 16'hA003, 16'hB801, 16'hB801,
                             16'hB901, 16'hBA01, 16'hBB01, 16'h8801, 16'hBC01};
  logic [3:0]  d_f  [20] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                             4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                             4'h0, 4'h0, 4'h0, 4'b0100, 4'b0000,
                             4'b1000, 4'b0000, 4'b0000, 4'h0, 4'h0};

  // Main sequence
  initial begin
    logic [15:0] r_ir;
    logic [3:0]  r_f;
    bus.exec = 1'b0;
    bus.ir = 16'h0000;
    bus.szcv = 4'h0;
    repeat (3) @(negedge clk);
    check_eq("in_reset", dut_vec(), '0);
    rst_n = 1'b1;
    idle_check("idle_no_exec", 20);

    press_exec();
    wait_running("start");
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      run_instr($sformatf("dir%0d_%h", k, d_ir[k]), d_ir[k], d_f[k], 1'b0);
    end
    for (int k = 0; k < 16; k++) begin
      r_ir = 16'($urandom_range(0, 16'hFFFF));
      r_f  = 4'($urandom_range(0, 15));
      if (r_ir[15:14] == 2'b11 && r_ir[7:4] == 4'hF) r_ir[7:4] = 4'h0;
      @(negedge clk);
      run_instr($sformatf("rnd_%h", r_ir), r_ir, r_f, 1'b0);
    end

    // Stop request in P2: instruction completes, then STOP; next press resumes at P1
    @(negedge clk);
    run_instr("stop_p2", 16'hC100, 4'h0, 1'b1);
    idle_check("stopped", 6);
    press_exec();
    wait_running("resume");
    run_instr("resume", 16'hC110, 4'h0, 1'b0);

    // HLT: halt after P5, exec ignored
    @(negedge clk);
    run_instr("hlt", 16'hC0F0, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("halted", dut_vec(), HALT_VEC);
    end
    press_exec();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("halt_ignores_exec", dut_vec(), HALT_VEC);
    end

    // Reset leaves HALT
    rst_n = 1'b0;
    #1;
    check_eq("rst_from_halt", dut_vec(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("after_rst", 3);

    // Reset during P3 of LD: no mem_read, back to STOP
    press_exec();
    wait_running("ld_start");
    bus.ir = 16'h0000;
    bus.szcv = 4'h0;
    #1;
    for (int p = 0; p < 3; p++) exp_q.push_back(model(16'h0000, 4'h0, p));
    for (int p = 0; p < 3; p++) begin
      if (p > 0) @(negedge clk);
      check_eq("ld_pre_rst", dut_vec(), exp_q.pop_front());
    end
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ld", dut_vec(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("no_mem_read", 10);

    // Free run continues back to back after the reset
    press_exec();
    wait_running("rerun");
    run_instr("rerun_a", 16'hC120, 4'h0, 1'b0);
    @(negedge clk);
    run_instr("rerun_b", 16'h0000, 4'h0, 1'b1);
    idle_check("rerun_stop", 4);

`ifdef SIMPLE_SINGLE_STEP_EN
    step = 1'b1;
    repeat (2) @(negedge clk);
    step = 1'b0;
    wait_running("step_start");
    run_instr("step", 16'hC130, 4'h0, 1'b0);
    idle_check("step_done", 6);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
